// File: rtl/tree_node_pkg.sv
// Shared types and constants for the tree node sequencer: FSM state encoding,
// launch-mode selectors and a popcount helper for the parallel done-mask.
package tree_node_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FINISH
  } state_e;

  localparam int MODE_SEQ     = 0;
  localparam int MODE_PAR     = 1;
  localparam int MAX_CHILDREN = 32;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/tree_node_timer.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches limit_i. A zero limit never expires.
module tree_node_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Expiry is flagged during the limit_i-th enabled cycle, not one cycle later.
  assign expired_o = en_i && (limit_i != '0) && ((cnt_q + W'(1)) == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                  cnt_d = '0;
    else if (en_i && !expired_o)  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tree_node_sequencer.sv
// Launches a set of child tasks either one at a time or all together, tracks
// their completion and reports a single done/err pulse per run.
module tree_node_sequencer
  import tree_node_pkg::*;
#(
  parameter int NUM_CHILDREN   = 5,
  parameter int MODE           = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic [NUM_CHILDREN-1:0]           child_start_o,
  input  logic [NUM_CHILDREN-1:0]           child_done_i,
  output logic [$clog2(NUM_CHILDREN+1)-1:0] done_cnt_o
);

  localparam int CW = $clog2(NUM_CHILDREN + 1);
  localparam int IW = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [NUM_CHILDREN-1:0] ALL_ONES = '1;
  localparam logic [IW-1:0]           LAST_IDX = IW'(NUM_CHILDREN - 1);

  if (NUM_CHILDREN < 1 || NUM_CHILDREN > MAX_CHILDREN) begin : g_bad_children
    $error("tree_node_sequencer: NUM_CHILDREN must be 1..32");
  end
  if (MODE != MODE_SEQ && MODE != MODE_PAR) begin : g_bad_mode
    $error("tree_node_sequencer: MODE must be 0 or 1");
  end

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_CHILDREN-1:0] mask_q, mask_d;
  logic [NUM_CHILDREN-1:0] cs_q, cs_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    tmr_expired;

  // LAUNCH always leads to WAIT, so clearing there restarts the timer on every WAIT entry.
  tree_node_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == ST_LAUNCH),
    .en_i      (state_q == ST_WAIT),
    .limit_i   (TW'(TIMEOUT_CYCLES)),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cs_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LAUNCH;
          idx_d   = '0;
          mask_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // A completion seen in the expiry cycle wins over the timeout.
        if (MODE == MODE_SEQ) begin
          if (child_done_i[idx_q]) begin
            cnt_d = cnt_q + CW'(1);
            if (idx_q == LAST_IDX) begin
              state_d = ST_FINISH;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = ST_LAUNCH;
            end
          end else if (tmr_expired) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end else begin
          mask_d = mask_q | child_done_i;
          cnt_d  = CW'(popcount32(32'(mask_d)));
          if (mask_d == ALL_ONES) begin
            state_d = ST_FINISH;
          end else if (tmr_expired) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (state_d == ST_LAUNCH)
      cs_d = (MODE == MODE_SEQ) ? (NUM_CHILDREN'(1) << idx_d) : ALL_ONES;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_FINISH);
  assign err_o         = (state_q == ST_FINISH) && err_q;
  assign child_start_o = cs_q;
  assign done_cnt_o    = cnt_q;

endmodule

// File: tb/tb_tree_node_sequencer.sv
// Directed bench: a sequential-launch and a parallel-launch instance, a
// cycle table for the parallel done-mask and hand sequences for timing corners.
module tb_tree_node_sequencer;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_a, start_b;
  logic [N-1:0] cdone_a, cdone_b;
  logic         busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [N-1:0] cs_a, cs_b;
  logic [2:0]   cnt_a, cnt_b;

  tree_node_sequencer #(.NUM_CHILDREN(N), .MODE(0), .TIMEOUT_CYCLES(10)) u_seq (
    .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .child_start_o(cs_a), .child_done_i(cdone_a), .done_cnt_o(cnt_a)
  );

  tree_node_sequencer #(.NUM_CHILDREN(N), .MODE(1), .TIMEOUT_CYCLES(10)) u_par (
    .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .child_start_o(cs_b), .child_done_i(cdone_b), .done_cnt_o(cnt_b)
  );

  typedef struct packed {
    logic         start;
    logic [N-1:0] cdone;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] cs;
    logic [2:0]   cnt;
  } vec_t;

  vec_t tbl [8];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from a sampled start until done_o is seen on the sequential unit.
  task automatic lat_a(output int cyc, output bit seen);
    cyc = 0; seen = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0; cyc = 1;
    for (int c = 0; c < 60 && !done_a; c++) begin tick(); cyc++; end
    seen = done_a;
  endtask

  initial begin
    int cyc, launches, pi, d, dones;
    bit seen, pend;

    tbl[0] = '{1'b1, 5'b00000, 1'b1, 1'b0, 1'b0, 5'b11111, 3'd0};
    tbl[1] = '{1'b1, 5'b00000, 1'b1, 1'b0, 1'b0, 5'b00000, 3'd0};
    tbl[2] = '{1'b1, 5'b00010, 1'b1, 1'b0, 1'b0, 5'b00000, 3'd1};
    tbl[3] = '{1'b1, 5'b01000, 1'b1, 1'b0, 1'b0, 5'b00000, 3'd2};
    tbl[4] = '{1'b1, 5'b01101, 1'b1, 1'b0, 1'b0, 5'b00000, 3'd4};
    tbl[5] = '{1'b1, 5'b10000, 1'b1, 1'b1, 1'b0, 5'b00000, 3'd5};
    tbl[6] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd5};
    tbl[7] = '{1'b0, 5'b11111, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd5};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; cdone_a = '0; cdone_b = '0;
    tick(); tick();
    chk("reset_seq_outputs", {busy_a, done_a, err_a, cs_a, cnt_a}, 0);
    chk("reset_par_outputs", {busy_b, done_b, err_b, cs_b, cnt_b}, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Parallel mode: repeated and simultaneous done bits, start held mid-run, done in IDLE.
    for (int i = 0; i < 8; i++) begin
      start_b = tbl[i].start; cdone_b = tbl[i].cdone;
      tick();
      chk($sformatf("par_vec%0d", i), {busy_b, done_b, err_b, cs_b, cnt_b},
          {tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].cs, tbl[i].cnt});
    end
    cdone_b = '0;

    // Parallel latency with every child done as soon as WAIT is reached.
    cdone_b = '1; start_b = 1'b1; tick(); start_b = 1'b0; cyc = 1;
    for (int c = 0; c < 60 && !done_b; c++) begin tick(); cyc++; end
    chk("par_latency", cyc, 3);
    chk("par_latency_err_cnt", {err_b, cnt_b}, {1'b0, 3'd5});
    tick();

    // Parallel timeout: child 4 never reports, ten WAIT cycles then error.
    cdone_b = 5'b01111; start_b = 1'b1; tick(); start_b = 1'b0; cyc = 1;
    for (int c = 0; c < 60 && !done_b; c++) begin tick(); cyc++; end
    chk("par_timeout_latency", cyc, 12);
    chk("par_timeout_err_cnt", {done_b, err_b, cnt_b}, {1'b1, 1'b1, 3'd4});
    cdone_b = '0; tick();

    // Sequential: each child reports three cycles after its own launch pulse.
    cdone_a = '0; start_a = 1'b1; tick(); start_a = 1'b0;
    launches = 0; pend = 1'b0; d = 0; pi = 0; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      cdone_a = '0;
      if (pend) begin
        if (d == 0) begin cdone_a = N'(1) << pi; pend = 1'b0; end
        else d--;
      end
      if (cs_a != '0) begin
        chk($sformatf("seq_launch%0d", launches), cs_a, N'(1) << launches);
        pi = launches; launches++; pend = 1'b1; d = 1;
      end
      if (done_a) begin seen = 1'b1; break; end
      tick();
    end
    chk("seq_run_done_err_cnt", {seen, err_a, cnt_a}, {1'b1, 1'b0, 3'd5});
    chk("seq_launch_count", launches, 5);
    cdone_a = '0; tick();
    chk("seq_idle_hold", {busy_a, done_a, cnt_a}, {1'b0, 1'b0, 3'd5});

    // Sequential latency with child_done tied high.
    cdone_a = '1; lat_a(cyc, seen);
    chk("seq_latency", cyc, 11);
    chk("seq_latency_err_cnt", {seen, err_a, cnt_a}, {1'b1, 1'b0, 3'd5});
    tick();

    // Sequential timeout: children 0,1 finish, child 2 silent for ten WAIT cycles.
    cdone_a = 5'b00011; start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 0; c < 60 && !cs_a[2]; c++) tick();
    cyc = 0;
    for (int c = 0; c < 60 && !done_a; c++) begin tick(); cyc++; end
    chk("seq_timeout_wait", cyc, 11);
    chk("seq_timeout_err_cnt", {done_a, err_a, cnt_a}, {1'b1, 1'b1, 3'd2});
    cdone_a = '0; tick();

    // Completion in the very cycle the timer expires counts as success.
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("tie_launch0", cs_a, 5'b00001);
    for (int c = 0; c < 10; c++) tick();
    chk("tie_still_waiting", {busy_a, done_a, cs_a}, {1'b1, 1'b0, 5'b00000});
    cdone_a = 5'b00001; tick();
    chk("tie_next_launch", {done_a, err_a, cs_a, cnt_a}, {1'b0, 1'b0, 5'b00010, 3'd1});
    cdone_a = '1;
    for (int c = 0; c < 60 && !done_a; c++) tick();
    chk("tie_final", {done_a, err_a, cnt_a}, {1'b1, 1'b0, 3'd5});
    cdone_a = '0; tick();

    // Asynchronous reset while waiting on child 1.
    cdone_a = 5'b00001; start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick(); tick();
    chk("rst_pre_state", {busy_a, cnt_a}, {1'b1, 3'd1});
    #2 rst = 1'b1;
    #1 chk("rst_immediate", {busy_a, done_a, err_a, cs_a, cnt_a}, 0);
    @(negedge clk); rst = 1'b0; cdone_a = '0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (done_a || busy_a) dones++; end
    chk("rst_no_done_or_busy", dones, 0);
    cdone_a = '1; lat_a(cyc, seen);
    chk("rst_clean_rerun", {cyc[7:0], seen, err_a, cnt_a}, {8'd11, 1'b1, 1'b0, 3'd5});
    tick();

    // start_i held high for the whole run: one launch per child, one done pulse.
    cdone_a = '1; start_a = 1'b1; launches = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (cs_a != '0) launches++;
      if (done_a) begin dones++; start_a = 1'b0; break; end
    end
    chk("hold_start_launches", launches, 5);
    chk("hold_start_dones", dones, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done_a || busy_a) dones++;
    end
    chk("hold_start_no_restart", {dones[7:0], cnt_a}, {8'd1, 3'd5});
    cdone_a = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
